// File: rtl/sched_pkg.sv
// Shared defaults and the queued-entry type for the scheduling observation stage.
package sched_pkg;

   localparam int SCHED_W     = 3;
   localparam int SCHED_DEPTH = 4;
   localparam int SCHED_CNTW  = 8;

   typedef struct packed {
      logic [SCHED_W-1:0]    data;
      logic [SCHED_CNTW-1:0] tag;
   } sched_entry_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO of tagged samples. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
module sched_fifo
   import sched_pkg::*;
#(
   parameter type entry_t = sched_entry_t,
   parameter int  DEPTH   = SCHED_DEPTH
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push,
   input  logic   pop,
   input  entry_t din,
   output entry_t dout,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);

   entry_t        mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_pop;
   logic          do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is only accepted when the same edge frees a slot.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/sched_obs_capture.sv
// Clocked observation stage: captures changed samples of a settled net vector with an index tag.
// Optional SCHED_XCHECK_EN: samples with X/Z bits are withheld from the queue and flagged.
module sched_obs_capture
   import sched_pkg::*;
#(
   parameter int W     = SCHED_W,
   parameter int DEPTH = SCHED_DEPTH,
   parameter int CNTW  = SCHED_CNTW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_i,
   input  logic [W-1:0]    obs_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [W-1:0]    out_data_o,
   output logic [CNTW-1:0] out_tag_o,
   output logic [CNTW-1:0] chg_cnt_o,
   output logic            overflow_o,
   output logic            err_x_o
);

   typedef struct packed {
      logic [W-1:0]    data;
      logic [CNTW-1:0] tag;
   } cap_entry_t;

   logic [W-1:0]    last_q;
   logic            last_vld_q;
   logic [CNTW-1:0] idx_q;
   logic [CNTW-1:0] chg_q;
   logic            ovf_q;
   logic            differs;
   logic            capture;
   logic            push_req;
   logic            pop;
   logic            full;
   logic            empty;
   cap_entry_t      din;
   cap_entry_t      head;

   // 4-state compare: a sample going from x11 to 111 counts as a change.
   assign differs = ~last_vld_q | (obs_i !== last_q);
   assign capture = en_i & differs;

`ifdef SCHED_XCHECK_EN
   logic x_sample;
   logic errx_q;

   assign x_sample = $isunknown(obs_i);
   assign push_req = capture & ~x_sample;
   assign err_x_o  = errx_q;

   always_ff @(posedge clk) begin
      if (rst) errx_q <= 1'b0;
      else if (capture && x_sample) errx_q <= 1'b1;
   end
`else
   assign push_req = capture;
   assign err_x_o  = 1'b0;
`endif

   // Handshake: the head transfers on a posedge where out_valid_o & out_ready_i;
   // out_valid_o is the registered FIFO state and never looks at out_ready_i.
   assign pop = ~empty & out_ready_i;

   assign din.data = obs_i;
   assign din.tag  = idx_q;

   sched_fifo #(
      .entry_t (cap_entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .din   (din),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
         idx_q      <= '0;
         chg_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         if (en_i) idx_q <= idx_q + 1'b1;
         if (capture) begin
            last_q     <= obs_i;
            last_vld_q <= 1'b1;
            if (chg_q != {CNTW{1'b1}}) chg_q <= chg_q + 1'b1;
         end
         if (push_req && full && !pop) ovf_q <= 1'b1;
      end
   end

   assign out_valid_o = ~empty;
   assign out_data_o  = empty ? '0 : head.data;
   assign out_tag_o   = empty ? '0 : head.tag;
   assign chg_cnt_o   = chg_q;
   assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_sched_obs_capture.sv
// Directed bench for sched_obs_capture: default instance plus a CNTW=2 instance for tag wrap.
module tb_sched_obs_capture;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] obs = 3'b000;
   logic       ready_a = 1'b0;
   logic       ready_b = 1'b1;

   logic       valid_a;
   logic [2:0] data_a;
   logic [7:0] tag_a;
   logic [7:0] chg_a;
   logic       ovf_a;
   logic       errx_a;

   logic       valid_b;
   logic [2:0] data_b;
   logic [1:0] tag_b;
   logic [1:0] chg_b;
   logic       ovf_b;
   logic       errx_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sched_obs_capture dut_a (
      .clk (clk), .rst (rst), .en_i (en), .obs_i (obs),
      .out_valid_o (valid_a), .out_ready_i (ready_a),
      .out_data_o (data_a), .out_tag_o (tag_a),
      .chg_cnt_o (chg_a), .overflow_o (ovf_a), .err_x_o (errx_a)
   );

   sched_obs_capture #(.CNTW(2)) dut_b (
      .clk (clk), .rst (rst), .en_i (en), .obs_i (obs),
      .out_valid_o (valid_b), .out_ready_i (ready_b),
      .out_data_o (data_b), .out_tag_o (tag_b),
      .chg_cnt_o (chg_b), .overflow_o (ovf_b), .err_x_o (errx_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; ready_a = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic sample(input logic [2:0] v);
      en = 1'b1; obs = v;
      tick();
   endtask

   task automatic drain_one();
      en = 1'b0; ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
   endtask

   logic [2:0] v_x;
   logic [2:0] v_z;
   logic       x_dist;
   logic       exp_push;
   logic       exp_err;
   logic [2:0] seq [5];

   initial begin
      v_x = 3'bx11;
      v_z = 3'b1z0;
      x_dist = (v_x !== 3'b111);
      seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b011; seq[3] = 3'b100; seq[4] = 3'b101;

      // reset state
      do_reset();
      check("rst_valid", valid_a, 0);
      check("rst_data", data_a, 0);
      check("rst_tag", tag_a, 0);
      check("rst_chg", chg_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_errx", errx_a, 0);

      // x11 then 111
      sample(v_x);
      check("t1_valid", valid_a, 1);
      check("t1_head_data", data_a, v_x);
      check("t1_head_tag", tag_a, 0);
      sample(3'b111);
      check("t1_chg", chg_a, x_dist ? 2 : 1);
      drain_one();
      check("t1_second_valid", valid_a, x_dist);
      check("t1_second_data", data_a, x_dist ? 3'b111 : 3'b000);
      check("t1_second_tag", tag_a, x_dist ? 1 : 0);
      drain_one();
      check("t1_empty", valid_a, 0);

      // held value: one entry, index keeps running
      do_reset();
      for (int i = 0; i < 5; i++) sample(3'b111);
      check("t2_chg", chg_a, 1);
      check("t2_head_data", data_a, 3'b111);
      check("t2_head_tag", tag_a, 0);
      sample(3'b010);
      check("t2_chg2", chg_a, 2);
      drain_one();
      check("t2_idx_tag", tag_a, 5);
      check("t2_idx_data", data_a, 3'b010);

      // overflow, then push+pop at full
      do_reset();
      for (int i = 0; i < 5; i++) sample(seq[i]);
      check("t3_valid", valid_a, 1);
      check("t3_head_data", data_a, 3'b001);
      check("t3_head_tag", tag_a, 0);
      check("t3_ovf", ovf_a, 1);
      check("t3_chg", chg_a, 5);
      ready_a = 1'b1;
      sample(3'b110);
      check("t3_pp_data", data_a, 3'b010);
      check("t3_pp_tag", tag_a, 1);
      check("t3_pp_chg", chg_a, 6);
      drain_one();
      check("t3_d1_tag", tag_a, 2);
      drain_one();
      check("t3_d2_tag", tag_a, 3);
      drain_one();
      check("t3_d3_tag", tag_a, 5);
      check("t3_d3_data", data_a, 3'b110);
      drain_one();
      check("t3_empty", valid_a, 0);
      check("t3_ovf_sticky", ovf_a, 1);

      // CNTW=2 instance: tag wrap and saturating change count
      do_reset();
      ready_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample(seq[i]);
         check($sformatf("t4_tag%0d", i), tag_b, i % 4);
         check($sformatf("t4_data%0d", i), data_b, seq[i]);
         check($sformatf("t4_chg%0d", i), chg_b, (i < 3) ? i + 1 : 3);
      end

      // reset flushes queued entries
      do_reset();
      sample(3'b001); sample(3'b010); sample(3'b100);
      check("t5_pre_valid", valid_a, 1);
      rst = 1'b1; en = 1'b0;
      tick();
      check("t5_valid", valid_a, 0);
      check("t5_data", data_a, 0);
      check("t5_tag", tag_a, 0);
      check("t5_chg", chg_a, 0);
      check("t5_ovf", ovf_a, 0);
      rst = 1'b0;
      sample(3'b100);
      check("t5_recap_valid", valid_a, 1);
      check("t5_recap_tag", tag_a, 0);
      check("t5_recap_data", data_a, 3'b100);

      // X/Z sample handling
      do_reset();
`ifdef SCHED_XCHECK_EN
      exp_push = !$isunknown(v_z);
      exp_err  = $isunknown(v_z);
`else
      exp_push = 1'b1;
      exp_err  = 1'b0;
`endif
      sample(v_z);
      check("t6_valid", valid_a, exp_push);
      check("t6_data", data_a, exp_push ? v_z : 3'b000);
      check("t6_errx", errx_a, exp_err);
      check("t6_chg", chg_a, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
